qq_mul_arbiter: RTL

- Shares one fixed-point quaternion multiplier (fixed_qq, instantiated inside) between NUM_REQ requesters, e.g. player heading, camera and obstacle orientation updates.
- Round-robin grants, valid/ready handshakes on request and response, fixed-latency sequencing of the multiplier, and a requester-ID tag on each result.
- Sits between the input/game-logic blocks and the render transform stage.

---
 rtl/qq_pkg.sv | 20 ++
 rtl/fixed_qq.sv | 55 +++++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/qq_mul_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/qq_pkg.sv
// Shared types and defaults for the fixed-point quaternion pipeline
// (multiplier, arbiter and renderer).
package qq_pkg;

    localparam int unsigned QQ_TOTAL_PREC = 18;
    localparam int unsigned QQ_FRAC_BITS  = 13;

    typedef logic signed [QQ_TOTAL_PREC-1:0] qcomp_t;
    // [3]=w, [2]=x, [1]=y, [0]=z
    typedef qcomp_t [3:0] quat_t;

    localparam quat_t QUAT_IDENT = {qcomp_t'(1 << QQ_FRAC_BITS), qcomp_t'(0), qcomp_t'(0), qcomp_t'(0)};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fixed_qq.sv
// Fixed-point Hamilton product a*b with a LATENCY-deep register pipeline.
// Results are truncated (floor) from the full-precision sum of products.
module fixed_qq #(
    parameter int unsigned TOTAL_PREC = 18,
    parameter int unsigned FRAC_BITS  = 13,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*TOTAL_PREC-1:0]   a,
    input  logic [4*TOTAL_PREC-1:0]   b,
    output logic [4*TOTAL_PREC-1:0]   res
);

    localparam int unsigned W  = TOTAL_PREC;
    localparam int unsigned PW = 2*TOTAL_PREC + 2;
    localparam logic [4*W-1:0] IDENT = {W'(1 << FRAC_BITS), (3*W)'(0)};

    logic signed [W-1:0]  aw, ax, ay, az, bw, bx, by, bz;
    logic signed [PW-1:0] sw, sx, sy, sz;
    logic [4*W-1:0]       prod;
    logic [4*W-1:0]       pipe [LATENCY];

    always_comb begin
        aw = a[3*W +: W];
        ax = a[2*W +: W];
        ay = a[1*W +: W];
        az = a[0*W +: W];
        bw = b[3*W +: W];
        bx = b[2*W +: W];
        by = b[1*W +: W];
        bz = b[0*W +: W];
        sw = PW'(aw)*PW'(bw) - PW'(ax)*PW'(bx) - PW'(ay)*PW'(by) - PW'(az)*PW'(bz);
        sx = PW'(aw)*PW'(bx) + PW'(ax)*PW'(bw) + PW'(ay)*PW'(bz) - PW'(az)*PW'(by);
        sy = PW'(aw)*PW'(by) - PW'(ax)*PW'(bz) + PW'(ay)*PW'(bw) + PW'(az)*PW'(bx);
        sz = PW'(aw)*PW'(bz) + PW'(ax)*PW'(by) - PW'(ay)*PW'(bx) + PW'(az)*PW'(bw);
        prod = {sw[FRAC_BITS +: W], sx[FRAC_BITS +: W], sy[FRAC_BITS +: W], sz[FRAC_BITS +: W]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe[i] <= IDENT;
            end
        end else begin
            pipe[0] <= prod;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign res = pipe[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational requester arbiter: round-robin from last_grant+1 by default,
// strict lowest-index priority when QQ_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic        found;
    int unsigned idx;

`ifdef QQ_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = k;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(last_grant) + 1 + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/qq_mul_arbiter.sv
// Shares one fixed_qq multiplier among NUM_REQ requesters with valid/ready
// handshakes and an ID-tagged response. Define QQ_ARB_FIXED_PRIO_EN for fixed priority.
module qq_mul_arbiter
    import qq_pkg::*;
#(
    parameter int unsigned TOTAL_PREC  = QQ_TOTAL_PREC,
    parameter int unsigned FRAC_BITS   = QQ_FRAC_BITS,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*4*TOTAL_PREC-1:0]   req_a,
    input  logic [NUM_REQ*4*TOTAL_PREC-1:0]   req_b,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [4*TOTAL_PREC-1:0]           rsp_res,
    output logic                              busy
);

    localparam int unsigned QW  = 4*TOTAL_PREC;
    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(MUL_LATENCY + 1);
    localparam logic [QW-1:0] IDENT = {TOTAL_PREC'(1 << FRAC_BITS), (3*TOTAL_PREC)'(0)};

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     last_grant_q;
    logic [IDW-1:0]     id_q;
    logic [CW-1:0]      cnt_q;
    logic [QW-1:0]      op_a_q, op_b_q, res_q;
    logic [QW-1:0]      mul_res;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    fixed_qq #(
        .TOTAL_PREC (TOTAL_PREC),
        .FRAC_BITS  (FRAC_BITS),
        .LATENCY    (MUL_LATENCY)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .a     (op_a_q),
        .b     (op_b_q),
        .res   (mul_res)
    );

    // Grants are masked while reset is high since the async reset forces IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    req_ready = grant;
                    accept    = |grant;
                end
                if (accept) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
            op_a_q       <= IDENT;
            op_b_q       <= IDENT;
            res_q        <= IDENT;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q       <= req_a[grant_idx*QW +: QW];
                op_b_q       <= req_b[grant_idx*QW +: QW];
                id_q         <= grant_idx;
                last_grant_q <= grant_idx;
                cnt_q        <= CW'(MUL_LATENCY);
            end
            // Capture one cycle after the counter hits zero so rsp_valid rises MUL_LATENCY+1 after accept.
            if (state_q == MUL) begin
                if (cnt_q == '0) begin
                    res_q <= mul_res;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_res   = res_q;
    assign busy      = (state_q != IDLE);

endmodule
